bomb_scheduler: RTL and testbench
=================================

# bomb_scheduler

Shared bomb-slot scheduler for the two-player arena. It owns a pool of bomb slots and arbitrates placement requests from both players, enforcing per-player caps and one-bomb-per-tile. Each live slot is sequenced through fuse and blast phases. It drives the packed bomb coordinate buses and a per-slot blast mask, which the movement, crack and end-flag logic consume.

## Interface
- NSLOT, 6: total slots in the pool; fixed at 6 to match the packed 36-bit buses.
- MAX_PER, 3: maximum live slots (FUSE or BLAST) owned by one player.
- FUSE_TICKS, 3: ticks from placement to blast; must be ≥1.
- BLAST_TICKS, 2: ticks a slot stays in blast; must be ≥1.
- clk  in  1  system clock; all state changes on the posedge.
- reset  in  1  synchronous, active-low reset, sampled on the clk posedge.
- tick  in  1  one-cycle timebase strobe for fuse and blast counting.
- freeze  in  1  game-over hold: when high, ticks are ignored and all requests are rejected.
- req1, req2  in  1  placement request pulses from player 1 and player 2.
- x1, y1, x2, y2  in  6 each  tile coordinates of each player, sampled together with the request.
- bomb_x, bomb_y  out  [1:36]  packed slot coordinates; slot k occupies bits 6k-5..6k, MSB first.
- blast  out  [1:6]  bit k is high while slot k is in BLAST.
- owner  out  [1:6]  bit k is 0 for player 1, 1 for player 2; valid only while slot k is live.
- gnt1, gnt2, rej1, rej2  out  1 each  one-cycle result pulses for each request.

## Operation
- Per-slot FSM:
  - IDLE → FUSE on grant: coordinates, owner and cnt=FUSE_TICKS are loaded.
  - FUSE: on a tick with cnt==1, go to BLAST with cnt=BLAST_TICKS; on any other tick, decrement cnt.
  - BLAST: on a tick with cnt==1, go to IDLE; on any other tick, decrement cnt.
  - A slot in IDLE drives bomb_x=bomb_y=6'h3F (off-grid, because the grid is 39×29) and blast=0.
- A request is valid only if all of the following hold:
  - freeze=0;
  - at least one IDLE slot exists;
  - the requester owns fewer than MAX_PER live slots;
  - no live slot already holds (x,y).
- A single valid request takes the lowest-index IDLE slot.
- Both requests valid in the same cycle:
  - Distinct tiles and ≥2 IDLE slots: both are granted. The priority holder gets the lower-index slot.
  - Same tile, or only one IDLE slot: only the priority holder is granted; the other player is rejected.
- Priority register `prio` resets to player 1. It flips to the other player only in cycles where it actually resolved a conflict.
- Every request produces exactly one gnt or rej pulse; none is dropped or queued.
- All occupancy, cap and tile checks use registered slot state as it was before the current edge.
  - A slot that leaves BLAST in the same cycle as a request is not available to that request.
  - A slot granted in the same cycle is not counted against the other player's simultaneous request, except for the same-tile rule.
- freeze=1: FSMs and counters hold their values, the outputs stay static, and any req produces a rej.

## Timing
- Reset values: every slot IDLE, bomb_x/bomb_y all 1s, blast=0, owner=0, gnt/rej=0, prio=player 1.
- A request sampled at edge N produces gnt/rej high during cycle N+1. Slot outputs update at the same edge.
- Fuse duration is exactly FUSE_TICKS tick pulses after the grant edge. A tick coinciding with the grant edge is not counted.
- blast rises on the edge of the FUSE_TICKS-th tick and falls on the edge of the following BLAST_TICKS-th tick.
- Reset asserted mid-operation returns all slots to IDLE at the next edge, with no blast emitted.
- Counter width is $clog2(max(FUSE_TICKS,BLAST_TICKS)+1). The counter never underflows.

## Test plan
- Reset, then req1 with (x1,y1)=(3,5) → gnt1 in the next cycle; slot 1 = (3,5), owner[1]=0; after 3 ticks blast[1]=1; after 2 more ticks slot 1 returns to (63,63).
- Four req1 pulses at distinct tiles → gnt1, gnt1, gnt1, rej1; the fourth is rejected by the cap with slots 4–6 still IDLE.
- req1 and req2 together at (1,1) and (7,7) from reset → both granted; slot 1 goes to P1 and slot 2 to P2; prio stays P1.
- req1 and req2 together at the same tile (2,2), repeated twice with a third tile the second time → first: gnt1/rej2 and prio flips to P2; second (same tile again): gnt2/rej1.
- Fill all 6 slots, then request in the tick cycle where slot 1 leaves BLAST → rej; the same request one cycle later → gnt into slot 1.
- Slot mid-fuse with freeze=1 and 5 ticks applied → cnt and state unchanged, req1 → rej1; then reset=0 for one cycle → all slots at 63, blast=0.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot pool for the two-player arena: arbitrates placement requests,
// enforces per-player caps and one-bomb-per-tile, and sequences each slot through fuse and blast.
module bomb_scheduler #(
  parameter int NSLOT       = 6,
  parameter int MAX_PER     = 3,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               freeze,
  input  logic               req1,
  input  logic               req2,
  input  logic [5:0]         x1,
  input  logic [5:0]         y1,
  input  logic [5:0]         x2,
  input  logic [5:0]         y2,
  output logic [1:6*NSLOT]   bomb_x,
  output logic [1:6*NSLOT]   bomb_y,
  output logic [1:NSLOT]     blast,
  output logic [1:NSLOT]     owner,
  output logic               gnt1,
  output logic               gnt2,
  output logic               rej1,
  output logic               rej2
);

  localparam int CW = $clog2(((FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS) + 1);
  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int LW = $clog2(NSLOT + 1);

  localparam logic [1:0]    ST_IDLE    = 2'd0;
  localparam logic [1:0]    ST_FUSE    = 2'd1;
  localparam logic [1:0]    ST_BLAST   = 2'd2;
  localparam logic [CW-1:0] FUSE_LOAD  = CW'(FUSE_TICKS);
  localparam logic [CW-1:0] BLAST_LOAD = CW'(BLAST_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [5:0]    OFF_GRID   = 6'h3F;
  localparam logic [LW-1:0] CAP        = LW'(MAX_PER);

  logic [1:0]      st_r   [NSLOT];
  logic [CW-1:0]   cnt_r  [NSLOT];
  logic [5:0]      sx_r   [NSLOT];
  logic [5:0]      sy_r   [NSLOT];
  logic            own_r  [NSLOT];
  logic            prio_r;

  logic [1:0]      st_s   [NSLOT];
  logic [CW-1:0]   cnt_s  [NSLOT];
  logic [5:0]      sx_s   [NSLOT];
  logic [5:0]      sy_s   [NSLOT];
  logic            own_s  [NSLOT];
  logic            prio_s;

  logic [LW-1:0]   idle_cnt_s, live1_s, live2_s;
  logic [IW-1:0]   first_s, second_s, s1_s, s2_s;
  logic            hit1_s, hit2_s, ok1_s, ok2_s, same_tile_s, g1_s, g2_s, tick_en_s;
  logic [1:6*NSLOT] bomb_x_s, bomb_y_s;
  logic [1:NSLOT]  blast_s, owner_s;

  // Occupancy scan of the registered slot state: idle slots, per-player live counts, tile hits.
  always_comb begin
    idle_cnt_s = '0;
    live1_s    = '0;
    live2_s    = '0;
    first_s    = '0;
    second_s   = '0;
    hit1_s     = 1'b0;
    hit2_s     = 1'b0;
    // Descending scan leaves the two lowest idle indices in first/second.
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (st_r[i] == ST_IDLE) begin
        idle_cnt_s = idle_cnt_s + LW'(1);
        second_s   = first_s;
        first_s    = IW'(i);
      end else begin
        if (own_r[i]) begin
          live2_s = live2_s + LW'(1);
        end else begin
          live1_s = live1_s + LW'(1);
        end
        hit1_s = hit1_s | ((sx_r[i] == x1) && (sy_r[i] == y1));
        hit2_s = hit2_s | ((sx_r[i] == x2) && (sy_r[i] == y2));
      end
    end
  end

  // Request validation and two-player arbitration.
  always_comb begin
    same_tile_s = (x1 == x2) && (y1 == y2);
    ok1_s = req1 && !freeze && (idle_cnt_s != '0) && (live1_s < CAP) && !hit1_s;
    ok2_s = req2 && !freeze && (idle_cnt_s != '0) && (live2_s < CAP) && !hit2_s;
    g1_s   = 1'b0;
    g2_s   = 1'b0;
    s1_s   = first_s;
    s2_s   = first_s;
    prio_s = prio_r;
    if (ok1_s && ok2_s) begin
      if (!same_tile_s && (idle_cnt_s >= LW'(2))) begin
        g1_s = 1'b1;
        g2_s = 1'b1;
        if (prio_r) begin
          s1_s = second_s;
        end else begin
          s2_s = second_s;
        end
      end else begin
        g1_s   = !prio_r;
        g2_s   = prio_r;
        prio_s = !prio_r;
      end
    end else begin
      g1_s = ok1_s;
      g2_s = ok2_s;
    end
  end

  // Per-slot next state: grant load, fuse/blast countdown, and registered output images.
  always_comb begin
    tick_en_s = tick && !freeze;
    bomb_x_s  = {(6*NSLOT){1'b1}};
    bomb_y_s  = {(6*NSLOT){1'b1}};
    blast_s   = '0;
    owner_s   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      st_s[i]  = st_r[i];
      cnt_s[i] = cnt_r[i];
      sx_s[i]  = sx_r[i];
      sy_s[i]  = sy_r[i];
      own_s[i] = own_r[i];
      if ((g1_s && (s1_s == IW'(i))) || (g2_s && (s2_s == IW'(i)))) begin
        st_s[i]  = ST_FUSE;
        cnt_s[i] = FUSE_LOAD;
        sx_s[i]  = (g1_s && (s1_s == IW'(i))) ? x1 : x2;
        sy_s[i]  = (g1_s && (s1_s == IW'(i))) ? y1 : y2;
        own_s[i] = !(g1_s && (s1_s == IW'(i)));
      end else begin
        case (st_r[i])
          ST_IDLE: begin
            st_s[i] = ST_IDLE;
          end
          ST_FUSE: begin
            if (!tick_en_s) begin
              cnt_s[i] = cnt_r[i];
            end else if (cnt_r[i] <= CNT_ONE) begin
              st_s[i]  = ST_BLAST;
              cnt_s[i] = BLAST_LOAD;
            end else begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end
          end
          ST_BLAST: begin
            if (!tick_en_s) begin
              cnt_s[i] = cnt_r[i];
            end else if (cnt_r[i] <= CNT_ONE) begin
              st_s[i]  = ST_IDLE;
              cnt_s[i] = '0;
            end else begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end
          end
          default: begin
            st_s[i]  = ST_IDLE;
            cnt_s[i] = '0;
          end
        endcase
      end
      bomb_x_s[6*i+1 +: 6] = (st_s[i] == ST_IDLE) ? OFF_GRID : sx_s[i];
      bomb_y_s[6*i+1 +: 6] = (st_s[i] == ST_IDLE) ? OFF_GRID : sy_s[i];
      blast_s[i+1]         = (st_s[i] == ST_BLAST);
      owner_s[i+1]         = own_s[i];
    end
  end

  // State, priority and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        st_r[i]  <= ST_IDLE;
        cnt_r[i] <= '0;
        sx_r[i]  <= OFF_GRID;
        sy_r[i]  <= OFF_GRID;
        own_r[i] <= 1'b0;
      end
      prio_r <= 1'b0;
      bomb_x <= {(6*NSLOT){1'b1}};
      bomb_y <= {(6*NSLOT){1'b1}};
      blast  <= '0;
      owner  <= '0;
      gnt1   <= 1'b0;
      gnt2   <= 1'b0;
      rej1   <= 1'b0;
      rej2   <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        st_r[i]  <= st_s[i];
        cnt_r[i] <= cnt_s[i];
        sx_r[i]  <= sx_s[i];
        sy_r[i]  <= sy_s[i];
        own_r[i] <= own_s[i];
      end
      prio_r <= prio_s;
      bomb_x <= bomb_x_s;
      bomb_y <= bomb_y_s;
      blast  <= blast_s;
      owner  <= owner_s;
      gnt1   <= g1_s;
      gnt2   <= g2_s;
      rej1   <= req1 && !g1_s;
      rej2   <= req2 && !g2_s;
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Randomized scoreboard bench for bomb_scheduler against a remaining-ticks slot model.
module tb_bomb_scheduler;
  localparam int NS = 6, MAXP = 3, FT = 3, BT = 2;

  logic clk = 1'b0;
  logic reset, tick, freeze, req1, req2;
  logic [5:0] x1, y1, x2, y2;
  logic [1:36] bomb_x, bomb_y;
  logic [1:6]  blast, owner;
  logic gnt1, gnt2, rej1, rej2;

  bomb_scheduler #(.NSLOT(NS), .MAX_PER(MAXP), .FUSE_TICKS(FT), .BLAST_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .freeze(freeze),
    .req1(req1), .req2(req2), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .blast(blast), .owner(owner),
    .gnt1(gnt1), .gnt2(gnt2), .rej1(rej1), .rej2(rej2)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] resp; int due; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: a live slot counts down the total ticks left until it is free again.
  bit         m_live [NS];
  bit         m_own  [NS];
  int         m_rem  [NS];
  logic [5:0] m_x    [NS];
  logic [5:0] m_y    [NS];
  bit         m_prio;

  logic [1:36] nxt_bx, nxt_by, cur_bx, cur_by;
  logic [1:6]  nxt_bl, nxt_own, nxt_mask, cur_bl, cur_own, cur_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bomb_x", 36'(bomb_x), 36'(cur_bx));
      check("bomb_y", 36'(bomb_y), 36'(cur_by));
      check("blast",  36'(blast),  36'(cur_bl));
      check("owner",  36'(owner & cur_mask), 36'(cur_own & cur_mask));
      if (gnt1 | rej1 | gnt2 | rej2) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp: got g1r1g2r2=%b%b%b%b expected no pulse", gnt1, rej1, gnt2, rej2);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp", 36'({gnt1, rej1, gnt2, rej2}), 36'(mon_e.resp));
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        mon_e = sb_q.pop_front();
        total++; bad++;
        $display("FAIL resp_timeout: got 0000 expected g1r1g2r2=%b", mon_e.resp);
      end
    end
  end

  task automatic cycle(input bit r1, input int ax1, input int ay1, input bit r2,
                       input int ax2, input int ay2, input bit t, input bit fz, input bit rs);
    int nfree, f1, f2, c1, c2, s1, s2;
    bit hit1, hit2, ok1, ok2, g1, g2;
    exp_t ne;
    req1 = r1; x1 = 6'(ax1); y1 = 6'(ay1);
    req2 = r2; x2 = 6'(ax2); y2 = 6'(ay2);
    tick = t; freeze = fz; reset = rs;
    if (!rs) begin
      for (int i = 0; i < NS; i++) m_live[i] = 1'b0;
      m_prio = 1'b0;
    end else begin
      nfree = 0; f1 = -1; f2 = -1; c1 = 0; c2 = 0; hit1 = 0; hit2 = 0;
      for (int i = 0; i < NS; i++) begin
        if (!m_live[i]) begin
          nfree++;
          if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
        end else begin
          if (m_own[i]) c2++; else c1++;
          if (m_x[i] == 6'(ax1) && m_y[i] == 6'(ay1)) hit1 = 1;
          if (m_x[i] == 6'(ax2) && m_y[i] == 6'(ay2)) hit2 = 1;
        end
      end
      ok1 = r1 && !fz && nfree > 0 && c1 < MAXP && !hit1;
      ok2 = r2 && !fz && nfree > 0 && c2 < MAXP && !hit2;
      g1 = 0; g2 = 0; s1 = f1; s2 = f1;
      if (ok1 && ok2) begin
        if (!(ax1 == ax2 && ay1 == ay2) && nfree >= 2) begin
          g1 = 1; g2 = 1;
          if (m_prio) s1 = f2; else s2 = f2;
        end else begin
          if (m_prio) g2 = 1; else g1 = 1;
          m_prio = !m_prio;
        end
      end else begin
        g1 = ok1; g2 = ok2;
      end
      if (t && !fz)
        for (int i = 0; i < NS; i++)
          if (m_live[i]) begin
            m_rem[i]--;
            if (m_rem[i] == 0) m_live[i] = 1'b0;
          end
      if (g1) begin m_live[s1] = 1; m_own[s1] = 0; m_rem[s1] = FT + BT; m_x[s1] = 6'(ax1); m_y[s1] = 6'(ay1); end
      if (g2) begin m_live[s2] = 1; m_own[s2] = 1; m_rem[s2] = FT + BT; m_x[s2] = 6'(ax2); m_y[s2] = 6'(ay2); end
      if (r1 || r2) begin
        ne.resp = {g1, r1 && !g1, g2, r2 && !g2};
        ne.due  = cyc + 1;
        sb_q.push_back(ne);
      end
    end
    for (int i = 0; i < NS; i++) begin
      nxt_bx[6*i+1 +: 6] = m_live[i] ? m_x[i] : 6'h3F;
      nxt_by[6*i+1 +: 6] = m_live[i] ? m_y[i] : 6'h3F;
      nxt_bl[i+1]   = m_live[i] && (m_rem[i] <= BT);
      nxt_own[i+1]  = m_own[i];
      nxt_mask[i+1] = m_live[i];
    end
    @(posedge clk);
    cur_bx = nxt_bx; cur_by = nxt_by; cur_bl = nxt_bl; cur_own = nxt_own; cur_mask = nxt_mask;
    #1;
  endtask

  task automatic idle(input bit t);
    cycle(0, 0, 0, 0, 0, 0, t, 0, 1);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [17:0] ones18;
    logic [35:0] ones36;
    bit fz_lvl;
    ones18 = '1;
    ones36 = '1;
    fz_lvl = 0;
    for (int i = 0; i < NS; i++) begin
      m_live[i] = 0; m_own[i] = 0; m_rem[i] = 0; m_x[i] = 6'h3F; m_y[i] = 6'h3F;
    end
    m_prio = 0;
    do_reset();
    do_reset();
    chk_en = 1'b1;
    check("rst_bomb_x", 36'(bomb_x), ones36);
    check("rst_blast", 36'(blast), 36'd0);
    check("rst_owner", 36'(owner), 36'd0);
    check("rst_pulses", 36'({gnt1, gnt2, rej1, rej2}), 36'd0);

    // Single placement through fuse and blast.
    cycle(1, 3, 5, 0, 0, 0, 0, 0, 1);
    check("t1_slot1", 36'({bomb_x[1:6], bomb_y[1:6]}), 36'({6'd3, 6'd5}));
    repeat (3) begin idle(1); idle(0); end
    check("t1_blast_on", 36'(blast[1]), 36'd1);
    repeat (2) begin idle(1); idle(0); end
    check("t1_freed", 36'(bomb_x[1:6]), 36'd63);

    // Per-player cap.
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1, k, 1, 0, 0, 0, 0, 0, 1);
    check("t2_slots456_idle", 36'(bomb_x[19:36]), 36'(ones18));

    // Simultaneous distinct tiles.
    do_reset();
    cycle(1, 1, 1, 1, 7, 7, 0, 0, 1);
    check("t3_owners", 36'(owner[1:2]), 36'(2'b01));

    // Same-tile conflicts flip priority.
    do_reset();
    cycle(1, 2, 2, 1, 2, 2, 0, 0, 1);
    cycle(1, 4, 4, 1, 4, 4, 0, 0, 1);

    // Full pool, slot frees on the request cycle.
    do_reset();
    cycle(1, 10, 0, 1, 11, 0, 0, 0, 1);
    cycle(1, 12, 0, 1, 13, 0, 0, 0, 1);
    cycle(1, 14, 0, 1, 15, 0, 0, 0, 1);
    repeat (4) idle(1);
    cycle(1, 20, 20, 0, 0, 0, 1, 0, 1);
    cycle(1, 20, 20, 0, 0, 0, 0, 0, 1);
    check("t5_slot1_reused", 36'(bomb_x[1:6]), 36'd20);

    // Freeze holds state, then mid-run reset.
    do_reset();
    cycle(1, 5, 5, 0, 0, 0, 0, 0, 1);
    idle(1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cycle(1, 6, 6, 0, 0, 0, 1, 1, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("t6_frozen_x", 36'(bomb_x[1:6]), 36'd5);
    idle(1); idle(1);
    check("t6_blast_after", 36'(blast[1]), 36'd1);
    do_reset();
    check("t6_reset_x", 36'(bomb_x), ones36);
    check("t6_reset_blast", 36'(blast), 36'd0);

    // Randomized traffic with small coordinates to force collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) fz_lvl = !fz_lvl;
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, fz_lvl, $urandom_range(0, 249) != 0);
    end

    repeat (3) idle(0);
    check("sb_drained", 36'(sb_q.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
